// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//   MEM pipeline stage, directly after EX. It runs the data-cache handshake
//   for loads and stores, asks the hazard unit to stall while the cache is
//   busy, and owns the MEM/WB register. wb_data also feeds the EX forwarding
//   path.
//
// Parameters
//   ADDR_W       dcache word-address width (dcache_addr = EX_MEM_alu[ADDR_W+1:2])
//   SWAP_ENDIAN  1: byte-reverse store data and load data between the
//                little-endian core and big-endian memory; 0: pass through
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ext_stall           stall from other sources; freezes MEM/WB
//   EX_MEM_*            EX/MEM register contents (control, Rd, address, store data)
//   dcache_ren/wen      read / write request (combinational)
//   dcache_addr/wdata   word address and byte-ordered store data (always driven)
//   dcache_rdata        load data, valid when request held and dcache_stall==0
//   dcache_stall        cache busy; the request is held while high
//   dmem_stall          stall request to pipeline control (combinational)
//   MEM_WB_regwrite/Rd  registered write-back control
//   wb_data             registered write-back value
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int ADDR_W      = 30,
    parameter bit SWAP_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_stall,
    input  logic              EX_MEM_regwrite,
    input  logic              EX_MEM_memtoreg,
    input  logic              EX_MEM_memread,
    input  logic              EX_MEM_memwrite,
    input  logic [4:0]        EX_MEM_Rd,
    input  logic [31:0]       EX_MEM_alu,
    input  logic [31:0]       EX_MEM_wdata,
    output logic              dcache_ren,
    output logic              dcache_wen,
    output logic [ADDR_W-1:0] dcache_addr,
    output logic [31:0]       dcache_wdata,
    input  logic [31:0]       dcache_rdata,
    input  logic              dcache_stall,
    output logic              dmem_stall,
    output logic              MEM_WB_regwrite,
    output logic [4:0]        MEM_WB_Rd,
    output logic [31:0]       wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] ldbuf_reg, ldbuf_next;

    logic        mem_op;
    logic        req;
    logic        wb_en;
    logic [31:0] rdata_sw;
    logic [31:0] wdata_sw;
    logic [31:0] ld_val;
    logic [31:0] wb_next;

    // Only the word-address slice of EX_MEM_alu reaches the cache; the
    // remaining bits are deliberately ignored.
    logic unused_alu_bits;
    assign unused_alu_bits = ^EX_MEM_alu;

    // Byte-lane reordering between core and memory.
    generate
        if (SWAP_ENDIAN) begin : g_swap
            for (genvar gi = 0; gi < 4; gi++) begin : g_byte
                assign rdata_sw[8*gi +: 8] = dcache_rdata[8*(3-gi) +: 8];
                assign wdata_sw[8*gi +: 8] = EX_MEM_wdata[8*(3-gi) +: 8];
            end
        end else begin : g_pass
            assign rdata_sw = dcache_rdata;
            assign wdata_sw = EX_MEM_wdata;
        end
    endgenerate

    assign mem_op = EX_MEM_memread | EX_MEM_memwrite;

    // No request in DONE: the access already happened while the pipeline
    // was frozen, so a store is never issued twice. Reset kills the request
    // in the same cycle, even when the state register held a live access.
    assign req        = rst_n & mem_op & (state_reg != DONE);
    assign dcache_wen = req & EX_MEM_memwrite;
    assign dcache_ren = req & EX_MEM_memread & ~EX_MEM_memwrite;

    assign dcache_addr  = EX_MEM_alu[ADDR_W+1:2];
    assign dcache_wdata = wdata_sw;

    // Deasserts in the completing cycle so a hit costs no bubble.
    assign dmem_stall = req & dcache_stall;

    // Next-state and load-buffer capture
    always_comb begin
        state_next = state_reg;
        ldbuf_next = ldbuf_reg;
        case (state_reg)
            IDLE, WAIT: begin
                if (req) begin
                    if (dcache_stall) begin
                        state_next = WAIT;
                    end else begin
                        // Access completes this cycle; keep the data in case
                        // the pipeline stays frozen past this edge.
                        ldbuf_next = rdata_sw;
                        state_next = ext_stall ? DONE : IDLE;
                    end
                end
            end
            DONE: begin
                if (!ext_stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ld_val  = (state_reg == DONE) ? ldbuf_reg : rdata_sw;
    assign wb_next = EX_MEM_memtoreg ? ld_val : EX_MEM_alu;
    assign wb_en   = ~ext_stall & ~dmem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            ldbuf_reg       <= 32'd0;
            MEM_WB_regwrite <= 1'b0;
            MEM_WB_Rd       <= 5'd0;
            wb_data         <= 32'd0;
        end else begin
            state_reg <= state_next;
            ldbuf_reg <= ldbuf_next;
            if (wb_en) begin
                // x0 is hard-wired zero, never written back
                MEM_WB_regwrite <= EX_MEM_regwrite & (EX_MEM_Rd != 5'd0);
                MEM_WB_Rd       <= EX_MEM_Rd;
                wb_data         <= wb_next;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//   Drives instruction-level transactions into mem_stage with a small
//   data-cache model (programmable latency, garbage read data when no read
//   completes) and compares MEM/WB results, stall cycles and cache traffic
//   against a word-level model of memory as the core sees it.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_stall = 1'b0;
    logic        EX_MEM_regwrite = 1'b0;
    logic        EX_MEM_memtoreg = 1'b0;
    logic        EX_MEM_memread = 1'b0;
    logic        EX_MEM_memwrite = 1'b0;
    logic [4:0]  EX_MEM_Rd = 5'd0;
    logic [31:0] EX_MEM_alu = 32'd0;
    logic [31:0] EX_MEM_wdata = 32'd0;
    logic        dcache_ren;
    logic        dcache_wen;
    logic [29:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic [31:0] dcache_rdata;
    logic        dcache_stall;
    logic        dmem_stall;
    logic        MEM_WB_regwrite;
    logic [4:0]  MEM_WB_Rd;
    logic [31:0] wb_data;

    mem_stage #(.ADDR_W(30), .SWAP_ENDIAN(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ext_stall       (ext_stall),
        .EX_MEM_regwrite (EX_MEM_regwrite),
        .EX_MEM_memtoreg (EX_MEM_memtoreg),
        .EX_MEM_memread  (EX_MEM_memread),
        .EX_MEM_memwrite (EX_MEM_memwrite),
        .EX_MEM_Rd       (EX_MEM_Rd),
        .EX_MEM_alu      (EX_MEM_alu),
        .EX_MEM_wdata    (EX_MEM_wdata),
        .dcache_ren      (dcache_ren),
        .dcache_wen      (dcache_wen),
        .dcache_addr     (dcache_addr),
        .dcache_wdata    (dcache_wdata),
        .dcache_rdata    (dcache_rdata),
        .dcache_stall    (dcache_stall),
        .dmem_stall      (dmem_stall),
        .MEM_WB_regwrite (MEM_WB_regwrite),
        .MEM_WB_Rd       (MEM_WB_Rd),
        .wb_data         (wb_data)
    );

    always #5 clk = ~clk;

    // ---------------- counters and helpers ----------------
    int n_vec = 0;
    int n_err = 0;
    bit aborted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Big-endian memory image after reset; word 1 holds 0x11223344.
    function automatic logic [31:0] init_word(input int i);
        return 32'h11223344 + 32'(i) * 32'h10101010 - 32'h10101010;
    endfunction

    // ---------------- data-cache model ----------------
    int          lat_sel = 0;   // stall cycles for the current access (driver-owned)
    int          stall_cnt;
    int          wr_comps;
    int          rd_comps;
    int          both_cnt;
    logic [31:0] junk;
    logic [31:0] mem_arr [16];

    assign dcache_stall = (dcache_ren | dcache_wen) && (stall_cnt < lat_sel);
    assign dcache_rdata = (dcache_ren && stall_cnt >= lat_sel) ? mem_arr[dcache_addr[3:0]] : junk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 0;
            junk      <= 32'hDEAD_BEEF;
            for (int i = 0; i < 16; i++) mem_arr[i] <= init_word(i);
        end else begin
            junk <= $urandom;
            if (dcache_ren | dcache_wen) begin
                if (dcache_ren && dcache_wen) both_cnt <= both_cnt + 1;
                if (stall_cnt < lat_sel) begin
                    stall_cnt <= stall_cnt + 1;
                end else begin
                    stall_cnt <= 0;
                    if (dcache_wen) begin
                        mem_arr[dcache_addr[3:0]] <= dcache_wdata;
                        wr_comps <= wr_comps + 1;
                    end else begin
                        rd_comps <= rd_comps + 1;
                    end
                end
            end
        end
    end

    initial begin
        wr_comps = 0;
        rd_comps = 0;
        both_cnt = 0;
    end

    // ---------------- reference model ----------------
    logic [31:0] shadow [16];   // memory contents as seen by the core
    logic [31:0] prev_wb = 32'd0;
    int          txn = 0;

    task automatic reinit_shadow();
        for (int i = 0; i < 16; i++) shadow[i] = bswap(init_word(i));
        prev_wb = 32'd0;
    endtask

    // Present one instruction and run it until it leaves MEM.
    // Called at posedge+1; returns at posedge+1.
    task automatic run_instr(input bit rw, input bit m2r, input bit mr, input bit mw,
                             input logic [4:0] rd, input logic [31:0] alu,
                             input logic [31:0] wdata, input int lat, input int hold);
        int          cyc;
        int          stalls;
        int          wr0;
        int          rd0;
        bit          adv;
        logic [3:0]  idx;
        logic [31:0] exp_wb;

        EX_MEM_regwrite = rw;
        EX_MEM_memtoreg = m2r;
        EX_MEM_memread  = mr;
        EX_MEM_memwrite = mw;
        EX_MEM_Rd       = rd;
        EX_MEM_alu      = alu;
        EX_MEM_wdata    = wdata;
        lat_sel         = lat;
        wr0             = wr_comps;
        rd0             = rd_comps;
        idx             = alu[5:2];
        exp_wb          = m2r ? shadow[idx] : alu;
        if (mw) shadow[idx] = wdata;
        cyc    = 0;
        stalls = 0;

        forever begin
            ext_stall = (cyc < hold);
            #1;
            if (cyc == 0) begin
                chk("addr",  {2'b00, dcache_addr}, {2'b00, alu[31:2]});
                chk("wdata", dcache_wdata, bswap(wdata));
            end
            if (dmem_stall) stalls++;
            adv = !ext_stall && !dmem_stall;
            @(posedge clk);
            #1;
            if (adv) break;
            chk("wb_hold", wb_data, prev_wb);
            cyc++;
            if (cyc > 60) begin
                chk("cycle_budget", 32'(cyc), 32'd60);
                aborted = 1'b1;
                break;
            end
        end

        chk("regwrite",   32'(MEM_WB_regwrite), 32'(rw && (rd != 5'd0)));
        chk("rd",         32'(MEM_WB_Rd), 32'(rd));
        chk("wb_data",    wb_data, exp_wb);
        chk("stall_cyc",  32'(stalls), (mr || mw) ? 32'(lat) : 32'd0);
        chk("store_cnt",  32'(wr_comps - wr0), 32'(mw));
        chk("load_cnt",   32'(rd_comps - rd0), 32'(mr && !mw));
        prev_wb = exp_wb;
        $display("txn %0d: rw=%0d m2r=%0d rd_op=%0d wr_op=%0d Rd=%0d alu=%08h lat=%0d ext=%0d -> wb=%08h rw=%0d Rd=%0d",
                 txn, rw, m2r, mr, mw, rd, alu, lat, hold, wb_data, MEM_WB_regwrite, MEM_WB_Rd);
        txn++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          kind;
        bit          rw;
        logic [4:0]  rd;
        logic [3:0]  idx;
        logic [31:0] alu;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_regwrite", 32'(MEM_WB_regwrite), 32'd0);
        chk("rst_rd",       32'(MEM_WB_Rd), 32'd0);
        chk("rst_wb",       wb_data, 32'd0);
        rst_n = 1'b1;
        reinit_shadow();
        @(posedge clk);
        #1;

        // ALU passthrough
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_0010, 32'd0, 0, 0);
        // x0 destination never writes back
        run_instr(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd0, 0, 0);
        // Load with a 3-cycle miss: address 0x41, big-endian word 0x11223344
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0104, 32'd0, 2, 0);
        chk("load_swap", wb_data, 32'h4433_2211);
        // Store completing under ext_stall, then a load of the same word
        run_instr(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0020, 32'hCAFE_F00D, 1, 4);
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0020, 32'd0, 0, 0);
        // Load completing while ext_stall holds for 3 cycles
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0008, 32'd0, 0, 3);

        // Reset in the middle of a stalled load
        EX_MEM_regwrite = 1'b1;
        EX_MEM_memtoreg = 1'b1;
        EX_MEM_memread  = 1'b1;
        EX_MEM_memwrite = 1'b0;
        EX_MEM_Rd       = 5'd4;
        EX_MEM_alu      = 32'h0000_0108;
        lat_sel         = 5;
        ext_stall       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ren",      32'(dcache_ren), 32'd0);
        chk("rst_wen",      32'(dcache_wen), 32'd0);
        chk("rst_dstall",   32'(dmem_stall), 32'd0);
        chk("rst_regwrite", 32'(MEM_WB_regwrite), 32'd0);
        chk("rst_rd",       32'(MEM_WB_Rd), 32'd0);
        chk("rst_wb",       wb_data, 32'd0);
        EX_MEM_memread  = 1'b0;
        EX_MEM_regwrite = 1'b0;
        EX_MEM_memtoreg = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reinit_shadow();
        // A fresh load must be requested immediately after release
        run_instr(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_000C, 32'd0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 250 && !aborted; n++) begin
            kind = int'($urandom_range(0, 3));
            rw   = 1'($urandom_range(0, 1));
            rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            idx  = 4'($urandom_range(0, 15));
            alu  = (kind == 0) ? 32'($urandom) : {26'd0, idx, 2'($urandom_range(0, 3))};
            run_instr(rw, kind == 1, kind == 1 || kind == 3, kind == 2 || kind == 3,
                      rd, alu, 32'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)));
        end

        chk("ren_wen_excl", 32'(both_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
